// File: rtl/ssd_display_controller.sv
// rtl/ssd_display_controller.sv - binary to BCD converter and 4-digit seven-segment scan driver
module ssd_display_controller #(
    parameter int DATA_W       = 13,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    output logic [3:0]        anode,
    output logic [6:0]        led_out,
    output logic              conv_busy,
    output logic              bcd_valid
);

    localparam int ITER_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_W-1:0]       bin_sr;
    logic [DATA_W-1:0]       last_value;
    logic [15:0]             bcd_work;
    logic [15:0]             bcd_adj;
    logic [15:0]             disp_bcd;
    logic [ITER_W-1:0]       iter;
    logic                    force_conv;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              digit_sel;
    logic [3:0]              digit;
    logic                    blank;
    logic [6:0]              seg;

    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < 4; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Only the DONE state touches disp_bcd, so partial results never reach the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bin_sr     <= '0;
            last_value <= '0;
            bcd_work   <= '0;
            disp_bcd   <= '0;
            iter       <= '0;
            force_conv <= 1'b1;
            conv_busy  <= 1'b0;
            bcd_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (force_conv || (value != last_value)) begin
                        bin_sr     <= value;
                        last_value <= value;
                        bcd_work   <= '0;
                        force_conv <= 1'b0;
                        iter       <= '0;
                        conv_busy  <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_work <= {bcd_adj[14:0], bin_sr[DATA_W-1]};
                    bin_sr   <= bin_sr << 1;
                    iter     <= iter + 1'b1;
                    if (iter == ITER_W'(DATA_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp_bcd  <= bcd_work;
                    bcd_valid <= 1'b1;
                    conv_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    conv_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign digit_sel = refresh_cnt[REFRESH_BITS-1 -: 2];

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        digit = disp_bcd[3:0];
        blank = 1'b0;
        case (digit_sel)
            2'd0: begin
                digit = disp_bcd[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                digit = disp_bcd[7:4];
                blank = (disp_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                digit = disp_bcd[11:8];
                blank = (disp_bcd[15:8] == 8'd0);
            end
            default: begin
                digit = disp_bcd[15:12];
                blank = (disp_bcd[15:12] == 4'd0);
            end
        endcase
    end

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode   <= 4'b1111;
            led_out <= 7'b1111111;
        end else if (!bcd_valid || blank) begin
            anode   <= 4'b1111;
            led_out <= 7'b1111111;
        end else begin
            anode   <= ~(4'b0001 << digit_sel);
            led_out <= seg;
        end
    end

endmodule

// File: tb/tb_ssd_display_controller.sv
// tb/tb_ssd_display_controller.sv - self-checking bench for ssd_display_controller
module tb_ssd_display_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic [3:0]  anode;
    logic [6:0]  led_out;
    logic        conv_busy;
    logic        bcd_valid;

    int n_pass  = 0;
    int n_total = 0;
    int edges;
    int cur;
    int nv;
    int busy_cnt;
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    ssd_display_controller #(
        .DATA_W      (13),
        .REFRESH_BITS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .anode    (anode),
        .led_out  (led_out),
        .conv_busy(conv_busy),
        .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scan slot after posedge k shows the digit picked by the counter value k-1.
    task automatic check_display(input int v, input int n);
        int sel;
        int p;
        logic [3:0] ea;
        logic [6:0] el;
        repeat (n) begin
            @(negedge clk);
            sel = ((edges - 1) % 16) / 4;
            p   = (sel == 0) ? 1 : (sel == 1) ? 10 : (sel == 2) ? 100 : 1000;
            if (sel != 0 && v < p) begin
                ea = 4'b1111;
                el = 7'b1111111;
            end else begin
                ea = ~(4'b0001 << sel);
                el = seg_tab[(v / p) % 10];
            end
            check($sformatf("anode v=%0d sel=%0d", v, sel), anode, ea);
            check($sformatf("led_out v=%0d sel=%0d", v, sel), led_out, el);
        end
    endtask

    task automatic convert(input int v);
        @(negedge clk);
        value = 13'(v);
        @(negedge clk);
        check("busy_after_start", conv_busy, 1);
        repeat (13) @(negedge clk);
        check("busy_at_e13", conv_busy, 1);
        @(negedge clk);
        check("busy_at_e14", conv_busy, 0);
        check("valid_at_e14", bcd_valid, 1);
        check_display(v, 16);
    endtask

    initial begin
        rst   = 1'b0;
        value = '0;
        #23;
        check("reset_anode", anode, 4'b1111);
        check("reset_led", led_out, 7'b1111111);
        check("reset_busy", conv_busy, 0);
        check("reset_valid", bcd_valid, 0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("first_start_busy", conv_busy, 1);
        repeat (13) @(negedge clk);
        check("valid_low_edge14", bcd_valid, 0);
        check("dark_edge14", anode, 4'b1111);
        @(negedge clk);
        check("valid_high_edge15", bcd_valid, 1);
        check("busy_low_edge15", conv_busy, 0);
        check_display(0, 16);
        cur = 0;

        convert(8191);
        cur = 8191;

        for (int i = 0; i < 8; i++) begin
            nv = cur;
            while (nv == cur || nv == 1234) begin
                case ($urandom_range(0, 3))
                    0:       nv = $urandom_range(0, 9);
                    1:       nv = $urandom_range(10, 99);
                    2:       nv = $urandom_range(100, 999);
                    default: nv = $urandom_range(1000, 8191);
                endcase
            end
            convert(nv);
            cur = nv;
        end

        // Value changes mid-conversion must wait for the next IDLE cycle.
        @(negedge clk);
        value = 13'd1234;
        @(negedge clk);
        check("busy_1234", conv_busy, 1);
        repeat (5) @(negedge clk);
        value = 13'd57;
        repeat (8) @(negedge clk);
        @(negedge clk);
        check("busy_end_1234", conv_busy, 0);
        check_display(1234, 1);
        check("busy_restart_57", conv_busy, 1);
        check_display(1234, 11);
        repeat (3) @(negedge clk);
        check("busy_end_57", conv_busy, 0);
        check_display(57, 16);

        @(negedge clk);
        rst   = 1'b0;
        value = 13'd405;
        @(negedge clk);
        rst      = 1'b1;
        busy_cnt = 0;
        repeat (1100) begin
            @(negedge clk);
            if (conv_busy) busy_cnt++;
        end
        check("busy_cycles_405", busy_cnt, 14);
        check_display(405, 16);

        @(negedge clk);
        value = 13'd999;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_anode", anode, 4'b1111);
        check("midreset_led", led_out, 7'b1111111);
        check("midreset_valid", bcd_valid, 0);
        check("midreset_busy", conv_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (14) @(negedge clk);
        check("rerun_valid_low", bcd_valid, 0);
        @(negedge clk);
        check("rerun_valid_high", bcd_valid, 1);
        check_display(999, 16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ssd_display_controller.md
Name: ssd_display_controller

Overview:
- Sequences the 4-digit seven-segment display from a 13-bit binary value produced by the CPU debug mux (e.g. selected PC/register/ALU bits).
- A multi-cycle double-dabble FSM converts the value to 4 BCD digits.
- A free-running refresh counter time-multiplexes the shared segment bus across the 4 anodes.
- Sits between the CPU's display-select output and the board's Anode/LED_out pins.

Parameters:
- DATA_W, 13, binary input width; fixed so the max value of 8191 fits 4 BCD digits.
- REFRESH_BITS, 18, refresh counter width; the top 2 bits select the digit. Benches use 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- value  input  13  binary value to display
- anode  output  4  digit enables, active-low; anode[0]=units, anode[3]=thousands
- led_out  output  7  segments {a,b,c,d,e,f,g}, active-low
- conv_busy  output  1  conversion in progress
- bcd_valid  output  1  display register holds a completed conversion

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE, refresh counter=0, display BCD register=0, last-value register=0.
  - anode=4'b1111, led_out=7'b1111111, conv_busy=0, bcd_valid=0.
  - A force flag is set.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Start a conversion if the force flag is set or value != last-value.
  - On start edge E0: capture value into the shift register and last-value, clear the BCD work register, clear the force flag, set iteration count=0, go to SHIFT.
- SHIFT, one iteration per cycle, 13 cycles (edges E1..E13):
  - Each BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - After the 13th iteration go to DONE.
- DONE, edge E14:
  - Copy the BCD work register to the display register.
  - Set bcd_valid=1 (it stays 1 until reset).
  - Go to IDLE.
- Conversion latency: the new digits are visible 14 edges after the start edge.
- conv_busy is 1 in SHIFT and DONE, 0 in IDLE.
- value changes during SHIFT/DONE are ignored. In the next IDLE cycle, value is compared against last-value and a new conversion starts if they differ. No intermediate or partial digits ever reach the display register.
- A constant value gives exactly one conversion after reset, then the FSM stays in IDLE.
- Refresh counter:
  - Free-running, wraps at 2^REFRESH_BITS. Runs independently of the FSM, including during conversion.
  - digit_sel = counter[REFRESH_BITS-1 : REFRESH_BITS-2]. Value 0 selects units, 3 selects thousands.
- anode and led_out are registered:
  - They reflect digit_sel one cycle later.
  - Exactly one anode bit is low, unless the selected digit is blanked.
- Blanking:
  - While bcd_valid=0, all digits are blanked: anode=1111, led_out=1111111.
  - Leading-zero blanking applies to the thousands, hundreds and tens digits when that digit and all higher digits are 0. The units digit is never blanked.
  - A blanked slot drives anode=1111 and led_out=1111111.
- Segment encoding (active-low, {a..g}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Nibbles >9 are unreachable; if they occur, output 1111111.
- Reset asserted mid-conversion:
  - Immediate return to the reset state; the display goes dark.
  - After release, a fresh conversion of the current value starts via the force flag.

Test Plan:
- Reset release with value=0, REFRESH_BITS=4:
  - Start on the first edge; bcd_valid rises 14 edges later.
  - Then anode cycles 1110 / 1111 / 1111 / 1111 (one per 4 cycles), with led_out=0000001 in the units slot.
- value=8191:
  - Display register=0x8191 after 14 edges.
  - Thousands slot: anode=0111, led_out=0000000 (8).
  - Units slot: anode=1110, led_out=1001111 (1).
- value=1234, then value=57 applied 5 cycles into the conversion:
  - 1234 completes and is displayed.
  - Next IDLE cycle starts a new conversion; display becomes 0057.
  - Hundreds and thousands slots blanked; tens slot shows 0100100.
- value held constant at 405:
  - conv_busy pulses high for exactly 14 cycles after reset, then stays 0 for 1000 cycles.
  - Tens slot shows 0000001 (embedded zero not blanked).
- rst asserted at iteration 7 of a conversion of 999:
  - anode=1111, led_out=1111111 and bcd_valid=0 asynchronously.
  - After release, 999 is reconverted and displayed 15 edges after release.
